// File: rtl/ddc_decim_ctrl.sv
// ddc_decim_ctrl
// Decimation-rate controller for the receive DDC chain (CIC -> hb1 -> hb2).
// Splits a total decimation D from the settings bus into a CIC rate plus
// halfband bypass bits and cpi values. A new setting is applied only after
// the chain has been drained and reset.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   set_stb/addr/data     : settings bus write (D = set_data[9:0])
//   run_in                : host run request
//   run_out               : run enable to CIC and both halfbands
//   chain_rst             : synchronous reset pulse to the datapath
//   cic_rate              : CIC decimation rate
//   hb1_bypass/hb2_bypass : halfband bypass controls
//   cpi_hb1/cpi_hb2       : clocks-per-input for each halfband
//   busy                  : reconfiguration pending or in progress
//   rate_err              : last accepted write was rejected (sticky)
//
// state | meaning
// IDLE  | chain stopped, configuration stable
// RUN   | chain running
// DRAIN | run dropped, letting samples flush out of the chain
// CLEAR | chain_rst asserted
// LOAD  | pending configuration copied to the outputs
module ddc_decim_ctrl #(
  parameter logic [7:0] SR_ADDR      = 8'd0,
  parameter int         DRAIN_CYCLES = 64,
  parameter int         CLEAR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        run_in,
  output logic        run_out,
  output logic        chain_rst,
  output logic [7:0]  cic_rate,
  output logic        hb1_bypass,
  output logic        hb2_bypass,
  output logic [8:0]  cpi_hb1,
  output logic [8:0]  cpi_hb2,
  output logic        busy,
  output logic        rate_err
);

  localparam int MAXC = (DRAIN_CYCLES > CLEAR_CYCLES) ? DRAIN_CYCLES : CLEAR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_CLEAR = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_pend;
  logic [7:0]      r_p_cic;
  logic            r_p_hb1_byp;
  logic            r_p_hb2_byp;

  logic            r_run_out;
  logic            r_chain_rst;
  logic            r_busy;
  logic            r_rate_err;
  logic [7:0]      r_cic;
  logic            r_hb1_byp;
  logic            r_hb2_byp;
  logic [8:0]      r_cpi_hb1;
  logic [8:0]      r_cpi_hb2;

  logic            w_wr;
  logic [9:0]      w_d;
  logic [9:0]      w_c;
  logic            w_hb1_byp;
  logic            w_hb2_byp;
  logic            w_rej;
  logic            w_unused_data;

  assign w_wr          = set_stb && (set_addr == SR_ADDR);
  assign w_d           = set_data[9:0];
  assign w_unused_data = ^set_data[31:10];

  // Prefer as many halfbands as the factors of two in D allow, but only
  // when each enabled halfband still gets cpi >= 2.
  always_comb begin
    w_c       = w_d;
    w_hb1_byp = 1'b1;
    w_hb2_byp = 1'b1;
    if ((w_d[1:0] == 2'b00) && (w_d >= 10'd8)) begin
      w_c       = {2'b00, w_d[9:2]};
      w_hb1_byp = 1'b0;
      w_hb2_byp = 1'b0;
    end else if (!w_d[0] && (w_d >= 10'd4)) begin
      w_c       = {1'b0, w_d[9:1]};
      w_hb2_byp = 1'b0;
    end
    w_rej = (w_d == 10'd0) || (w_c > 10'd255);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_p_cic     <= 8'd1;
      r_p_hb1_byp <= 1'b1;
      r_p_hb2_byp <= 1'b1;
      r_run_out   <= 1'b0;
      r_chain_rst <= 1'b0;
      r_busy      <= 1'b0;
      r_rate_err  <= 1'b0;
      r_cic       <= 8'd1;
      r_hb1_byp   <= 1'b1;
      r_hb2_byp   <= 1'b1;
      r_cpi_hb1   <= 9'd1;
      r_cpi_hb2   <= 9'd1;
    end else begin
      r_run_out   <= (r_state == S_RUN);
      r_chain_rst <= (r_state == S_CLEAR);
      r_busy      <= (r_state inside {S_DRAIN, S_CLEAR, S_LOAD}) || r_pend;

      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_state <= S_CLEAR;
            r_cnt   <= CLEAR_LD;
          end else if (run_in) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_pend || !run_in) begin
            r_state <= S_DRAIN;
            r_cnt   <= DRAIN_LD;
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= S_CLEAR;
            r_cnt   <= CLEAR_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == '0) r_state <= S_LOAD;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_LOAD: begin
          if (r_pend) begin
            r_cic     <= r_p_cic;
            r_hb1_byp <= r_p_hb1_byp;
            r_hb2_byp <= r_p_hb2_byp;
            r_cpi_hb1 <= {1'b0, r_p_cic};
            r_cpi_hb2 <= r_p_hb1_byp ? {1'b0, r_p_cic} : {r_p_cic, 1'b0};
          end
          r_pend  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Placed after the FSM so a write landing in LOAD re-arms the flag.
      if (w_wr) begin
        if (w_rej) begin
          r_rate_err <= 1'b1;
        end else begin
          r_rate_err  <= 1'b0;
          r_pend      <= 1'b1;
          r_p_cic     <= w_c[7:0];
          r_p_hb1_byp <= w_hb1_byp;
          r_p_hb2_byp <= w_hb2_byp;
        end
      end
    end
  end

  assign run_out    = r_run_out;
  assign chain_rst  = r_chain_rst;
  assign busy       = r_busy;
  assign rate_err   = r_rate_err;
  assign cic_rate   = r_cic;
  assign hb1_bypass = r_hb1_byp;
  assign hb2_bypass = r_hb2_byp;
  assign cpi_hb1    = r_cpi_hb1;
  assign cpi_hb2    = r_cpi_hb2;

endmodule
